// File: rtl/uart_loopback_fifo.sv
// UART loopback with a byte FIFO between receiver and transmitter.
// Received bytes are optionally transformed, buffered and echoed in order.
// Contains the uart_rx and uart_tx cores it uses.

module uart_rx #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  output logic [7:0] rdata,
  output logic       rx_ready,
  output logic       ferr,
  input  logic       rxd,
  input  logic       clk,
  input  logic       rstn
);
  localparam int CW = (2 * CLK_PER_HALF_BIT > 1) ? $clog2(2 * CLK_PER_HALF_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(2 * CLK_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            rxd_meta, rxd_sync, rxd_prev;

  // Two-flop synchronizer plus one delayed copy for start-edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Frame receiver: start on a falling edge, sample every bit in its middle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rdata    <= '0;
      rx_ready <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_ready <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rxd_prev && !rxd_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rxd_sync, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            rdata    <= shreg;
            ferr     <= !rxd_sync;
            rx_ready <= 1'b1;
            state    <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

module uart_tx #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic [7:0] data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       txd,
  input  logic       clk,
  input  logic       rstn
);
  localparam int CW = (2 * CLK_PER_HALF_BIT > 1) ? $clog2(2 * CLK_PER_HALF_BIT) : 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(2 * CLK_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Frame transmitter: start bit, 8 data bits LSB first, one stop bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          txd <= 1'b1;
          cnt <= '0;
          if (tx_start) begin
            shreg   <= data;
            tx_busy <= 1'b1;
            txd     <= 1'b0;
            state   <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= TX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            tx_busy <= 1'b0;
            state   <= TX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end
endmodule

module uart_loopback_fifo #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int FIFO_AW          = 4,
  parameter int MODE             = 0,
  parameter int DROP_FERR        = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rxd,
  output logic               txd,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic [7:0]         ferr_count
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} tx_ctrl_t;

  tx_ctrl_t           state;
  logic [7:0]         rx_data;
  logic               rx_ready;
  logic               rx_ferr;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_busy;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [7:0]         wdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               push;
  logic               pop;

  uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
    .rdata    (rx_data),
    .rx_ready (rx_ready),
    .ferr     (rx_ferr),
    .rxd      (rxd),
    .clk      (clk),
    .rstn     (rstn)
  );

  uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
    .data     (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .txd      (txd),
    .clk      (clk),
    .rstn     (rstn)
  );

  function automatic logic [7:0] transform(input logic [7:0] b);
    logic is_alpha;
    is_alpha = ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
    case (MODE)
      1:       return ~b;
      2:       return is_alpha ? (b ^ 8'h20) : b;
      default: return b;
    endcase
  endfunction

  // FIFO status, the byte to store and the push/pop decisions for this cycle.
  always_comb begin
    fifo_full  = (fifo_count == FULL_COUNT);
    fifo_empty = (fifo_count == '0);
    wdata      = transform(rx_data);
    accept     = rx_ready && !(rx_ferr && (DROP_FERR != 0));
    pop        = (state == IDLE) && !fifo_empty && !tx_busy;
    push       = accept && (!fifo_full || pop);
  end

  // Storage array; written without reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (accept && !push) overflow <= 1'b1;
    end
  end

  // Saturating count of frames that arrived with a bad stop bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ferr_count <= '0;
    end else if (rx_ready && rx_ferr && (ferr_count != 8'hFF)) begin
      ferr_count <= ferr_count + 1'b1;
    end
  end

  // Transmit controller: hand one FIFO byte at a time to the UART transmitter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if (pop) begin
            tx_data  <= mem[rptr];
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx_start <= 1'b0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Testbench for uart_loopback_fifo: three configurations share one rxd line,
// each txd is decoded and compared against a per-instance expected-byte queue.

module tb_uart_loopback_fifo;
  localparam int H   = 8;
  localparam int BIT = 2 * H;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       txd_a, txd_b, txd_c;
  logic [2:0] cnt_a;
  logic [4:0] cnt_b, cnt_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic [7:0] ferr_a, ferr_b, ferr_c;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [7:0] exp_q_c[$];
  int         frames[3];
  int         assert_count = 0;
  int         fail_count = 0;
  int         reset_count = 0;
  logic [7:0] inj_data = 8'h00;
  int         snap_a, snap_c;

  // Echo, small FIFO, drops framing errors.
  uart_loopback_fifo #(.CLK_PER_HALF_BIT(H), .FIFO_AW(2), .MODE(0), .DROP_FERR(1)) dut_a (
    .clk(clk), .rstn(rstn), .rxd(rxd), .txd(txd_a),
    .fifo_count(cnt_a), .overflow(ovf_a), .ferr_count(ferr_a));

  // Invert, forwards framing errors.
  uart_loopback_fifo #(.CLK_PER_HALF_BIT(H), .FIFO_AW(4), .MODE(1), .DROP_FERR(0)) dut_b (
    .clk(clk), .rstn(rstn), .rxd(rxd), .txd(txd_b),
    .fifo_count(cnt_b), .overflow(ovf_b), .ferr_count(ferr_b));

  // Case swap, drops framing errors.
  uart_loopback_fifo #(.CLK_PER_HALF_BIT(H), .FIFO_AW(4), .MODE(2), .DROP_FERR(1)) dut_c (
    .clk(clk), .rstn(rstn), .rxd(rxd), .txd(txd_c),
    .fifo_count(cnt_c), .overflow(ovf_c), .ferr_count(ferr_c));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] model(input int mode, input logic [7:0] b);
    if (mode == 1) return ~b;
    if (mode == 2 && (((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A))))
      return b ^ 8'h20;
    return b;
  endfunction

  function automatic logic txd_of(input int idx);
    if (idx == 0) return txd_a;
    if (idx == 1) return txd_b;
    return txd_c;
  endfunction

  // Returns the next expected byte, or an out-of-range marker if none is pending.
  function automatic logic [8:0] pop_exp(input int idx);
    if (idx == 0) return (exp_q_a.size() == 0) ? 9'h1FF : {1'b0, exp_q_a.pop_front()};
    if (idx == 1) return (exp_q_b.size() == 0) ? 9'h1FF : {1'b0, exp_q_b.pop_front()};
    return (exp_q_c.size() == 0) ? 9'h1FF : {1'b0, exp_q_c.pop_front()};
  endfunction

  task automatic monitorTx(input int idx);
    logic [7:0] b;
    logic       stop_bit;
    int         rc;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && txd_of(idx) === 1'b0) begin
        rc = reset_count;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = txd_of(idx);
        end
        repeat (BIT) @(negedge clk);
        stop_bit = txd_of(idx);
        if (rc == reset_count) begin
          frames[idx]++;
          checkOutput($sformatf("echo_byte_%0d", idx), {24'h0, b}, {23'h0, pop_exp(idx)});
          checkOutput($sformatf("echo_stop_%0d", idx), {31'h0, stop_bit}, 32'h1);
        end
      end
    end
  endtask

  // Sends one serial frame on rxd and records what each instance should echo.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) exp_q_a.push_back(model(0, b));
    exp_q_b.push_back(model(1, b));
    if (stop_bit) exp_q_c.push_back(model(2, b));
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Presents n consecutive receive events straight to instance A's FIFO input.
  task automatic inject_a(input int n, input logic [7:0] base);
    @(negedge clk);
    inj_data = base;
    force dut_a.rx_data  = inj_data;
    force dut_a.rx_ferr  = 1'b0;
    force dut_a.rx_ready = 1'b1;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      inj_data = base + 8'(i);
    end
    @(negedge clk);
    release dut_a.rx_ready;
    release dut_a.rx_ferr;
    release dut_a.rx_data;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((exp_q_a.size() + exp_q_b.size() + exp_q_c.size()) > 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", 32'(exp_q_a.size() + exp_q_b.size() + exp_q_c.size()), 32'h0);
    repeat (2 * BIT) @(negedge clk);
  endtask

  initial begin
    fork
      monitorTx(0);
      monitorTx(1);
      monitorTx(2);
    join_none

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cnt_a", 32'(cnt_a), 32'h0);
    checkOutput("rst_cnt_b", 32'(cnt_b), 32'h0);
    checkOutput("rst_ovf_a", 32'(ovf_a), 32'h0);
    checkOutput("rst_ferr_a", 32'(ferr_a), 32'h0);
    checkOutput("rst_txd_a", 32'(txd_a), 32'h1);
    checkOutput("rst_txd_c", 32'(txd_c), 32'h1);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] single byte 0x41");
    applyStimulus(8'h41, 1'b1);
    wait_drain(40 * BIT);
    checkOutput("after41_cnt_a", 32'(cnt_a), 32'h0);
    checkOutput("after41_ferr_a", 32'(ferr_a), 32'h0);

    $display("[TB] single byte 0x0F");
    applyStimulus(8'h0F, 1'b1);
    wait_drain(40 * BIT);

    $display("[TB] back-to-back 0x61 0x5A 0x31");
    applyStimulus(8'h61, 1'b1);
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'h31, 1'b1);
    wait_drain(80 * BIT);
    checkOutput("b2b_ovf_a", 32'(ovf_a), 32'h0);
    checkOutput("b2b_cnt_c", 32'(cnt_c), 32'h0);

    $display("[TB] frame error byte 0x55");
    snap_a = frames[0];
    snap_c = frames[2];
    applyStimulus(8'h55, 1'b0);
    wait_drain(40 * BIT);
    repeat (20 * BIT) @(negedge clk);
    checkOutput("ferr_frames_a", 32'(frames[0] - snap_a), 32'h0);
    checkOutput("ferr_frames_c", 32'(frames[2] - snap_c), 32'h0);
    checkOutput("ferr_count_a", 32'(ferr_a), 32'h1);
    checkOutput("ferr_count_b", 32'(ferr_b), 32'h1);
    checkOutput("ferr_count_c", 32'(ferr_c), 32'h1);

    $display("[TB] overflow on 4-deep FIFO");
    for (int i = 0; i < 5; i++) exp_q_a.push_back(model(0, 8'hA0 + 8'(i)));
    inject_a(6, 8'hA0);
    checkOutput("ovf_cnt_a", 32'(cnt_a), 32'h4);
    checkOutput("ovf_flag_a", 32'(ovf_a), 32'h1);
    checkOutput("ovf_flag_b", 32'(ovf_b), 32'h0);
    wait_drain(80 * BIT);
    checkOutput("ovf_sticky_a", 32'(ovf_a), 32'h1);
    checkOutput("ovf_drained_a", 32'(cnt_a), 32'h0);

    $display("[TB] reset with bytes buffered");
    inject_a(4, 8'hB0);
    checkOutput("pre_rst_cnt_a", 32'(cnt_a), 32'h3);
    rstn = 1'b0;
    reset_count++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_cnt_a", 32'(cnt_a), 32'h0);
    checkOutput("mid_rst_ovf_a", 32'(ovf_a), 32'h0);
    checkOutput("mid_rst_txd_a", 32'(txd_a), 32'h1);
    checkOutput("mid_rst_ferr_b", 32'(ferr_b), 32'h0);
    rstn = 1'b1;
    snap_a = frames[0];
    repeat (30 * BIT) @(negedge clk);
    checkOutput("post_rst_frames_a", 32'(frames[0] - snap_a), 32'h0);
    checkOutput("post_rst_cnt_a", 32'(cnt_a), 32'h0);
    checkOutput("post_rst_txd_a", 32'(txd_a), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
